// File: rtl/ulight_fifo_link_pkg.sv
// Shared definitions for the ulight link start sequencer: FSM encoding,
// register map and CTRL/STATUS bit positions.
package ulight_fifo_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_RUN = 3'd2,
    ST_RUN      = 3'd3,
    ST_BACKOFF  = 3'd4,
    ST_FAULT    = 3'd5
  } link_state_t;

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_TIMEOUT   = 2'd1;
  localparam logic [1:0] ADDR_RETRY_MAX = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_AUTO_BIT      = 1;
  localparam int CTRL_CLR_FAULT_BIT = 2;

  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_RETRY_LSB = 4;
  localparam int STATUS_LOSS_LSB  = 8;
  localparam int STATUS_RUN_BIT   = 16;
  localparam int STATUS_FAULT_BIT = 17;

endpackage

// File: rtl/ulight_fifo_link_regs.sv
// Avalon-MM register file for the link start sequencer: CTRL, TIMEOUT and
// RETRY_MAX storage plus the zero-wait read mux including the live STATUS word.
module ulight_fifo_link_regs
  import ulight_fifo_link_pkg::*;
#(
  parameter int TIMEOUT_W       = 16,
  parameter int RETRY_W         = 4,
  parameter int DEFAULT_TIMEOUT = 5000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  link_state_t          state,
  input  logic [RETRY_W-1:0]   retry_cnt,
  input  logic [7:0]           loss_cnt,
  input  logic                 link_run,
  input  logic                 fault,
  output logic                 enable,
  output logic                 auto_mode,
  output logic [TIMEOUT_W-1:0] timeout,
  output logic [RETRY_W-1:0]   retry_max,
  output logic                 clr_fault,
  output logic                 clr_loss
);

  logic wr;
  logic unused_wdata;

  assign wr           = chipselect && !write_n;
  assign clr_fault    = wr && (address == ADDR_CTRL) && writedata[CTRL_CLR_FAULT_BIT];
  assign clr_loss     = wr && (address == ADDR_STATUS);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      auto_mode <= 1'b0;
      timeout   <= TIMEOUT_W'(DEFAULT_TIMEOUT);
      retry_max <= RETRY_W'(3);
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          enable    <= writedata[CTRL_ENABLE_BIT];
          auto_mode <= writedata[CTRL_AUTO_BIT];
        end
        ADDR_TIMEOUT:   timeout   <= writedata[TIMEOUT_W-1:0];
        ADDR_RETRY_MAX: retry_max <= writedata[RETRY_W-1:0];
        default: ;
      endcase
    end
  end

  // clr_fault is a strobe only, so it never reads back
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE_BIT] = enable;
        readdata[CTRL_AUTO_BIT]   = auto_mode;
      end
      ADDR_TIMEOUT:   readdata = 32'(timeout);
      ADDR_RETRY_MAX: readdata = 32'(retry_max);
      default: begin
        readdata[STATUS_STATE_LSB +: 3] = state;
        readdata[STATUS_RETRY_LSB +: 4] = 4'(retry_cnt);
        readdata[STATUS_LOSS_LSB +: 8]  = loss_cnt;
        readdata[STATUS_RUN_BIT]        = link_run;
        readdata[STATUS_FAULT_BIT]      = fault;
      end
    endcase
  end

endmodule

// File: rtl/ulight_fifo_link_ctrl.sv
// Start sequencer for the ulight SpaceWire link: brings the link up, backs off
// and retries on timeout or loss, and latches a fault once the retry budget is spent.
module ulight_fifo_link_ctrl
  import ulight_fifo_link_pkg::*;
#(
  parameter int TIMEOUT_W       = 16,
  parameter int RETRY_W         = 4,
  parameter int DEFAULT_TIMEOUT = 5000,
  parameter int BACKOFF_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_run,
  input  logic        link_err,
  output logic        auto_start,
  output logic        link_start,
  output logic        link_disable,
  output logic        fault_irq
);

  // state    | meaning
  // IDLE     | link held disabled; waits for enable with no fault latched
  // START    | one cycle; loads the run timeout and requests link start
  // WAIT_RUN | start requested; waits for link_run or timeout
  // RUN      | link up; any drop of link_run or link_err counts a loss
  // BACKOFF  | link held disabled for BACKOFF_CYCLES before the next attempt
  // FAULT    | retry budget spent; link disabled until clr_fault

  localparam int              BO_W    = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF_CYCLES);

  link_state_t          state, state_nx;
  logic [TIMEOUT_W-1:0] timer, timer_nx, timeout, timeout_eff;
  logic [BO_W-1:0]      backoff, backoff_nx;
  logic [RETRY_W-1:0]   retry_cnt, retry_nx, retry_max;
  logic [7:0]           loss_cnt, loss_nx;
  logic                 fault, fault_nx;
  logic                 enable, auto_mode, clr_fault, clr_loss;
  logic                 active;

  ulight_fifo_link_regs #(
    .TIMEOUT_W      (TIMEOUT_W),
    .RETRY_W        (RETRY_W),
    .DEFAULT_TIMEOUT(DEFAULT_TIMEOUT)
  ) u_regs (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .state     (state),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .link_run  (link_run),
    .fault     (fault),
    .enable    (enable),
    .auto_mode (auto_mode),
    .timeout   (timeout),
    .retry_max (retry_max),
    .clr_fault (clr_fault),
    .clr_loss  (clr_loss)
  );

  assign timeout_eff = (timeout == '0) ? TIMEOUT_W'(1) : timeout;
  assign fault_irq   = fault;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    backoff_nx = backoff;
    retry_nx   = retry_cnt;
    loss_nx    = loss_cnt;
    fault_nx   = fault;
    if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!fault) state_nx = ST_START;
        ST_START: begin
          timer_nx = timeout_eff;
          state_nx = ST_WAIT_RUN;
        end
        ST_WAIT_RUN: begin
          // link_run wins over a timeout expiring in the same cycle
          if (link_run) begin
            state_nx = ST_RUN;
            retry_nx = '0;
          end else if (timer == TIMEOUT_W'(1)) begin
            if (retry_cnt == retry_max) begin
              state_nx = ST_FAULT;
              fault_nx = 1'b1;
            end else begin
              retry_nx   = retry_cnt + RETRY_W'(1);
              state_nx   = ST_BACKOFF;
              backoff_nx = BO_LOAD;
            end
          end else begin
            timer_nx = timer - TIMEOUT_W'(1);
          end
        end
        ST_RUN: begin
          if (!link_run || link_err) begin
            if (loss_cnt != 8'hFF) loss_nx = loss_cnt + 8'd1;
            retry_nx   = '0;
            state_nx   = ST_BACKOFF;
            backoff_nx = BO_LOAD;
          end
        end
        ST_BACKOFF: begin
          if (backoff == BO_W'(1)) state_nx = ST_START;
          else                     backoff_nx = backoff - BO_W'(1);
        end
        ST_FAULT: if (clr_fault) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
    if (clr_fault) begin
      fault_nx = 1'b0;
      retry_nx = '0;
    end
    if (clr_loss) loss_nx = '0;
    active = (state_nx == ST_START) || (state_nx == ST_WAIT_RUN) || (state_nx == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      timer        <= '0;
      backoff      <= '0;
      retry_cnt    <= '0;
      loss_cnt     <= '0;
      fault        <= 1'b0;
      link_disable <= 1'b1;
      link_start   <= 1'b0;
      auto_start   <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      backoff      <= backoff_nx;
      retry_cnt    <= retry_nx;
      loss_cnt     <= loss_nx;
      fault        <= fault_nx;
      link_disable <= !active;
      link_start   <= active;
      auto_start   <= active && auto_mode;
    end
  end

endmodule

// File: tb/tb_ulight_fifo_link_ctrl.sv
// Scoreboard bench for ulight_fifo_link_ctrl: directed phases plus random soak,
// checked every cycle against a behavioural model of the sequencer.
module tb_ulight_fifo_link_ctrl;

  localparam int BACKOFF_CYCLES = 64;
  localparam int S_IDLE = 0, S_START = 1, S_WAIT = 2, S_RUN = 3, S_BACKOFF = 4, S_FAULT = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        link_run = 1'b0;
  logic        link_err = 1'b0;
  logic        auto_start, link_start, link_disable, fault_irq;

  always #5 clk = ~clk;

  ulight_fifo_link_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .link_run(link_run), .link_err(link_err), .auto_start(auto_start),
    .link_start(link_start), .link_disable(link_disable), .fault_irq(fault_irq)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        dis;
    logic        start;
    logic        auto_o;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model: phase + elapsed-cycle counts, updated once per clock edge
  int m_state, m_timeout, m_rmax, m_retry, m_loss, m_elapsed, m_limit, m_bo;
  bit m_en, m_auto, m_fault, o_dis, o_start, o_auto;

  task automatic model_reset();
    m_state = S_IDLE; m_timeout = 5000; m_rmax = 3; m_retry = 0; m_loss = 0;
    m_elapsed = 0; m_limit = 1; m_bo = 0;
    m_en = 0; m_auto = 0; m_fault = 0; o_dis = 1; o_start = 0; o_auto = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [1:0] a, input logic [31:0] wd,
                            input bit lr, input bit err);
    int nst;
    bit clr, up;
    clr = wr && (a == 2'd0) && wd[2];
    nst = m_state;
    if (!m_en) nst = S_IDLE;
    else if (m_state == S_IDLE) begin
      if (!m_fault) nst = S_START;
    end else if (m_state == S_START) begin
      nst = S_WAIT; m_elapsed = 0; m_limit = (m_timeout == 0) ? 1 : m_timeout;
    end else if (m_state == S_WAIT) begin
      m_elapsed++;
      if (lr) begin nst = S_RUN; m_retry = 0; end
      else if (m_elapsed >= m_limit) begin
        if (m_retry == m_rmax) begin nst = S_FAULT; m_fault = 1; end
        else begin m_retry = (m_retry + 1) % 16; nst = S_BACKOFF; m_bo = 0; end
      end
    end else if (m_state == S_RUN) begin
      if (!lr || err) begin
        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        m_retry = 0; nst = S_BACKOFF; m_bo = 0;
      end
    end else if (m_state == S_BACKOFF) begin
      m_bo++;
      if (m_bo == BACKOFF_CYCLES) nst = S_START;
    end else if (m_state == S_FAULT) begin
      if (clr) nst = S_IDLE;
    end
    up = (nst == S_START) || (nst == S_WAIT) || (nst == S_RUN);
    o_dis = !up; o_start = up; o_auto = up && m_auto;
    if (wr) begin
      case (a)
        2'd0: begin m_en = wd[0]; m_auto = wd[1]; end
        2'd1: m_timeout = int'(wd[15:0]);
        2'd2: m_rmax = int'(wd[3:0]);
        default: m_loss = 0;
      endcase
    end
    if (clr) begin m_fault = 0; m_retry = 0; end
    m_state = nst;
  endtask

  function automatic exp_t expect_now(input logic [1:0] a, input logic lr);
    exp_t e;
    e.rd = '0;
    case (a)
      2'd0: begin e.rd[0] = m_en; e.rd[1] = m_auto; end
      2'd1: e.rd = 32'(m_timeout);
      2'd2: e.rd = 32'(m_rmax);
      default: e.rd = 32'(m_state) | (32'(m_retry) << 4) | (32'(m_loss) << 8)
                      | (32'(lr) << 16) | (32'(m_fault) << 17);
    endcase
    e.dis = o_dis; e.start = o_start; e.auto_o = o_auto; e.irq = m_fault;
    return e;
  endfunction

  // called at posedge+1: drive one cycle, queue its expectation, advance the model
  task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] wd, input logic lr, input logic err);
    chipselect = cs; write_n = wn; address = a; writedata = wd; link_run = lr; link_err = err;
    exp_q.push_back(expect_now(a, lr));
    @(posedge clk);
    model_edge(cs && !wn, a, wd, lr, err);
    #1;
  endtask

  task automatic rd_cycle(input logic lr, input logic err);
    cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom, lr, err);
  endtask

  task automatic wr_cycle(input logic [1:0] a, input logic [31:0] wd, input logic lr, input logic err);
    cycle(1'b1, 1'b0, a, wd, lr, err);
  endtask

  task automatic do_reset_mid();
    chipselect = 1'b0; write_n = 1'b1; link_err = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    exp_q.push_back(expect_now(address, link_run));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic bound_fail(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL bound_%s: model state %0d after cycle budget, required target state not reached", what, m_state);
  endtask

  exp_t e_mon, a_mon;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        a_mon = {readdata, link_disable, link_start, auto_start, fault_irq};
        n_checks++;
        if (a_mon !== e_mon) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t addr=%0d: actual rd=%h dis=%b start=%b auto=%b irq=%b, required rd=%h dis=%b start=%b auto=%b irq=%b",
                   $time, address, a_mon.rd, a_mon.dis, a_mon.start, a_mon.auto_o, a_mon.irq,
                   e_mon.rd, e_mon.dis, e_mon.start, e_mon.auto_o, e_mon.irq);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, extra, p;
    logic [1:0]  a;
    logic [31:0] wd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset values on all four addresses
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'(i), '0, 1'b0, 1'b0);

    // TIMEOUT=10, link_run rises on the 4th WAIT_RUN cycle
    wr_cycle(2'd1, 32'd10, 1'b0, 1'b0);
    wr_cycle(2'd0, 32'h3, 1'b0, 1'b0);
    n = 0;
    while (m_state != S_RUN && n < 40) begin
      rd_cycle(m_state == S_WAIT && m_elapsed >= 3, 1'b0); n++;
    end
    if (m_state != S_RUN) bound_fail("first_run");
    repeat (6) rd_cycle(1'b1, 1'b0);

    // one-cycle link_err in RUN, backoff, then recover
    rd_cycle(1'b1, 1'b1);
    n = 0;
    while (m_state != S_RUN && n < 120) begin
      rd_cycle(m_state == S_WAIT, 1'b0); n++;
    end
    if (m_state != S_RUN) bound_fail("rerun");
    cycle(1'b0, 1'b1, 2'd3, '0, 1'b1, 1'b0);
    wr_cycle(2'd3, $urandom, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, '0, 1'b1, 1'b0);

    // retry exhaustion: TIMEOUT=5, RETRY_MAX=2, link never runs
    wr_cycle(2'd0, 32'h0, 1'b1, 1'b0);
    repeat (2) rd_cycle(1'b0, 1'b0);
    wr_cycle(2'd1, 32'd5, 1'b0, 1'b0);
    wr_cycle(2'd2, 32'd2, 1'b0, 1'b0);
    wr_cycle(2'd0, 32'h1, 1'b0, 1'b0);
    n = 0;
    while (m_state != S_FAULT && n < 400) begin rd_cycle(1'b0, 1'b0); n++; end
    if (m_state != S_FAULT) bound_fail("fault");
    repeat (3) rd_cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, '0, 1'b0, 1'b0);

    // clear fault with enable kept, then disable mid WAIT_RUN
    wr_cycle(2'd0, 32'h5, 1'b0, 1'b0);
    n = 0;
    while (!(m_state == S_WAIT && m_elapsed == 2) && n < 20) begin rd_cycle(1'b0, 1'b0); n++; end
    if (m_state != S_WAIT) bound_fail("wait_run");
    wr_cycle(2'd0, 32'h0, 1'b0, 1'b0);
    repeat (3) rd_cycle(1'b0, 1'b0);
    wr_cycle(2'd0, 32'h1, 1'b0, 1'b0);
    n = 0;
    while (m_state != S_RUN && n < 20) begin rd_cycle(m_state == S_WAIT, 1'b0); n++; end
    if (m_state != S_RUN) bound_fail("run_before_reset");
    repeat (4) rd_cycle(1'b1, 1'b0);
    do_reset_mid();

    // random soak
    wr_cycle(2'd0, 32'h1, 1'b0, 1'b0);
    p = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 40 == 0) p = (i % 120 == 0) ? 5 : ((i % 120 == 40) ? 50 : 95);
      if (i % 1500 == 1499) do_reset_mid();
      else if ($urandom_range(0, 99) < 8) begin
        a = 2'($urandom_range(0, 3));
        wd = $urandom;
        case (a)
          2'd0: wd = {29'd0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0)};
          2'd1: wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
          2'd2: wd = (wd & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
          default: ;
        endcase
        wr_cycle(a, wd, ($urandom_range(0, 99) < p), ($urandom_range(0, 19) == 0));
      end else begin
        rd_cycle(($urandom_range(0, 99) < p), ($urandom_range(0, 19) == 0));
      end
    end

    // loss counter saturation at 255
    do_reset_mid();
    wr_cycle(2'd0, 32'h1, 1'b0, 1'b0);
    n = 0; extra = 0;
    while (extra < 3 && n < 20000) begin
      if (m_state == S_RUN && m_loss == 255) extra++;
      rd_cycle(1'b1, m_state == S_RUN); n++;
    end
    if (extra < 3) bound_fail("loss_sat");
    cycle(1'b0, 1'b1, 2'd3, '0, 1'b1, 1'b0);
    repeat (2) rd_cycle(1'b1, 1'b0);

    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
